// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings,
// FSM state encoding and the access-size byte mask helper.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Byte mask for an access of 1, 2, 4 or 8 bytes, lane 0 aligned.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables,
// load extract with sign/zero extension, and the alignment check.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 st_f3_i,
    input  logic [$clog2(XLEN/8)-1:0]  st_off_i,
    input  logic [XLEN-1:0]            st_data_i,
    input  logic                       is_store_i,
    output logic [XLEN-1:0]            st_wdata_o,
    output logic [XLEN/8-1:0]          st_be_o,
    output logic                       misaligned_o,
    input  logic [2:0]                 ld_f3_i,
    input  logic [$clog2(XLEN/8)-1:0]  ld_off_i,
    input  logic [XLEN-1:0]            ld_rdata_i,
    output logic [XLEN-1:0]            ld_data_o
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [1:0] st_sz;
    logic [3:0] nbytes;
    logic [3:0] amask;

    // Store side: replicate the low element across every lane.
    always_comb begin
        st_sz  = st_f3_i[1:0];
        nbytes = 4'd1 << st_sz;
        amask  = nbytes - 4'd1;
        for (int i = 0; i < NB; i++) begin
            st_wdata_o[8*i +: 8] = st_data_i[8*(i % int'(nbytes)) +: 8];
        end
        st_be_o = NB'(size_mask(st_sz)) << st_off_i;
        misaligned_o = (|(st_off_i & OW'(amask)))
                     | ((st_sz == 2'd3) && (XLEN == 32))
                     | (is_store_i & st_f3_i[2]);
    end

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] lowmask;
    logic [NB-1:0]   bm;
    logic            sign;

    // Load side: shift the addressed lane down, mask, then extend.
    always_comb begin
        shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        bm      = NB'(size_mask(ld_f3_i[1:0]));
        lowmask = '0;
        sign    = 1'b0;
        for (int i = 0; i < NB; i++) begin
            lowmask[8*i +: 8] = {8{bm[i]}};
            if (bm[i]) sign = shifted[8*i+7];
        end
        ld_data_o = shifted & lowmask;
        if (!ld_f3_i[2] && sign) ld_data_o = ld_data_o | ~lowmask;
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage between execute and writeback with valid/ready on the
// pipeline side and a req/ack RAM port with optional ack timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     data_in,
    input  logic                in_RegWrite,
    input  logic [4:0]          in_RegDest,
    input  logic                in_MemToReg,
    output logic                out_valid,
    output logic [XLEN-1:0]     data_out,
    output logic [XLEN-1:0]     out_AluResult,
    output logic                out_RegWrite,
    output logic [4:0]          out_RegDest,
    output logic                out_MemToReg,
    output logic                fault_misaligned,
    output logic                fault_bus,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    lsu_state_e state_q, state_d;

    logic [XLEN-1:0]   alu_q, alu_d;
    logic [XLEN-1:0]   dout_q, dout_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [NB-1:0]     be_q, be_d;
    logic [OW-1:0]     off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              m2r_q, m2r_d;
    logic              we_q, we_d;
    logic              fmis_q, fmis_d;
    logic              fbus_q, fbus_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              accept, is_mem, is_store, misal, timeout;
    logic [XLEN-1:0]   st_wdata, ld_data;
    logic [NB-1:0]     st_be;

    assign accept   = in_valid & in_ready;
    assign is_mem   = MemRead | MemWrite;
    assign is_store = MemWrite & ~MemRead;
    assign timeout  = (ACK_TIMEOUT > 0) && (state_q == REQ) && !mem_ack
                    && (cnt_q == CW'(ACK_TIMEOUT - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_f3_i      (funct3),
        .st_off_i     (addr[OW-1:0]),
        .st_data_i    (data_in),
        .is_store_i   (is_store),
        .st_wdata_o   (st_wdata),
        .st_be_o      (st_be),
        .misaligned_o (misal),
        .ld_f3_i      (f3_q),
        .ld_off_i     (off_q),
        .ld_rdata_i   (mem_rdata),
        .ld_data_o    (ld_data)
    );

    // State register; async reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (!is_mem || misal) ? RESP : REQ;
            REQ:  if (mem_ack || timeout) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and RAM strobes decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        stall     = (state_q != IDLE);
        out_valid = (state_q == RESP);
        mem_req   = (state_q == REQ);
        mem_we    = (state_q == REQ) & we_q;
        mem_be    = (state_q == REQ) ? be_q : '0;
    end

    // Datapath next-state: capture on accept, complete in REQ.
    always_comb begin
        alu_d   = alu_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;
        maddr_d = maddr_q;
        be_d    = be_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        m2r_d   = m2r_q;
        we_d    = we_q;
        fmis_d  = fmis_q;
        fbus_d  = fbus_q;
        cnt_d   = cnt_q;
        if (accept) begin
            alu_d   = addr;
            rd_d    = in_RegDest;
            m2r_d   = in_MemToReg;
            rw_d    = in_RegWrite & ~(is_mem & misal);
            fmis_d  = is_mem & misal;
            fbus_d  = 1'b0;
            dout_d  = '0;
            off_d   = addr[OW-1:0];
            f3_d    = funct3;
            cnt_d   = '0;
            maddr_d = ADDR_W'(addr & ~XLEN'(NB - 1));
            we_d    = is_mem & ~misal & is_store;
            wdata_d = (is_mem & ~misal & is_store) ? st_wdata : '0;
            be_d    = (is_mem & ~misal) ? (is_store ? st_be : '1) : '0;
        end else if (state_q == REQ) begin
            if (mem_ack) begin
                if (!we_q) dout_d = ld_data;
            end else if (timeout) begin
                fbus_d = 1'b1;
                rw_d   = 1'b0;
                dout_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q   <= '0;
            dout_q  <= '0;
            wdata_q <= '0;
            maddr_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            we_q    <= 1'b0;
            fmis_q  <= 1'b0;
            fbus_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            alu_q   <= alu_d;
            dout_q  <= dout_d;
            wdata_q <= wdata_d;
            maddr_q <= maddr_d;
            be_q    <= be_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            we_q    <= we_d;
            fmis_q  <= fmis_d;
            fbus_q  <= fbus_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out         = dout_q;
    assign out_AluResult    = alu_q;
    assign out_RegWrite     = rw_q;
    assign out_RegDest      = rd_q;
    assign out_MemToReg     = m2r_q;
    assign fault_misaligned = fmis_q;
    assign fault_bus        = fbus_q;
    assign mem_addr         = maddr_q;
    assign mem_wdata        = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit instance with an ack
// timeout and a 64-bit instance, each backed by a small RAM responder.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk, rst;

    logic        in_valid, in_ready, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, data_in;
    logic        in_RegWrite, in_MemToReg;
    logic [4:0]  in_RegDest;
    logic        out_valid, out_RegWrite, out_MemToReg;
    logic [31:0] data_out, out_AluResult;
    logic [4:0]  out_RegDest;
    logic        fault_misaligned, fault_bus, stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        w_in_valid, w_in_ready, w_MemRead, w_MemWrite;
    logic [2:0]  w_funct3;
    logic [63:0] w_addr, w_data_in;
    logic        w_out_valid, w_out_RegWrite, w_out_MemToReg;
    logic [63:0] w_data_out, w_out_AluResult;
    logic [4:0]  w_out_RegDest;
    logic        w_fault_misaligned, w_fault_bus, w_stall;
    logic        w_mem_req, w_mem_we, w_mem_ack;
    logic [31:0] w_mem_addr;
    logic [63:0] w_mem_wdata, w_mem_rdata;
    logic [7:0]  w_mem_be;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .ACK_TIMEOUT(8)) u32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .addr(addr), .data_in(data_in),
        .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest),
        .in_MemToReg(in_MemToReg),
        .out_valid(out_valid), .data_out(data_out),
        .out_AluResult(out_AluResult), .out_RegWrite(out_RegWrite),
        .out_RegDest(out_RegDest), .out_MemToReg(out_MemToReg),
        .fault_misaligned(fault_misaligned), .fault_bus(fault_bus),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32), .ACK_TIMEOUT(0)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .MemRead(w_MemRead), .MemWrite(w_MemWrite), .funct3(w_funct3),
        .addr(w_addr), .data_in(w_data_in),
        .in_RegWrite(1'b1), .in_RegDest(5'd3), .in_MemToReg(1'b0),
        .out_valid(w_out_valid), .data_out(w_data_out),
        .out_AluResult(w_out_AluResult), .out_RegWrite(w_out_RegWrite),
        .out_RegDest(w_out_RegDest), .out_MemToReg(w_out_MemToReg),
        .fault_misaligned(w_fault_misaligned), .fault_bus(w_fault_bus),
        .stall(w_stall), .mem_req(w_mem_req), .mem_we(w_mem_we),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_be(w_mem_be),
        .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:15];
    int          wc;
    int          ack_delay;
    bit          never_ack;

    assign mem_ack   = mem_req && !never_ack && (wc == ack_delay);
    assign mem_rdata = ram[mem_addr[5:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wc <= 0;
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            if (mem_req && !mem_ack) wc <= wc + 1;
            else                     wc <= 0;
            if (mem_req && mem_ack && mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b])
                        ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    logic [63:0] ram64;
    assign w_mem_ack   = w_mem_req;
    assign w_mem_rdata = ram64;

    always @(posedge clk) begin
        if (w_mem_req && w_mem_we)
            for (int b = 0; b < 8; b++)
                if (w_mem_be[b]) ram64[8*b +: 8] <= w_mem_wdata[8*b +: 8];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int          lat, req_n;
    bit          stable, stall_ok;
    logic [31:0] r_addr, r_wdata, v_data, v_alu;
    logic [3:0]  r_be;
    logic        r_we, v_rw, v_fm, v_fb, post_valid, post_ready;
    logic [4:0]  v_rd;

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3;
        addr = a; data_in = d; in_RegWrite = 1'b1;
        in_RegDest = 5'd7; in_MemToReg = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        lat = 0; req_n = 0; stable = 1; stall_ok = 1;
        r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
        v_data = 'x; v_alu = 'x; v_rw = 1'bx; v_fm = 1'bx;
        v_fb = 1'bx; v_rd = 'x;
        issue(rd, wr, f3, a, d);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!stall) stall_ok = 0;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    r_addr = mem_addr; r_wdata = mem_wdata;
                    r_be = mem_be; r_we = mem_we;
                end else if (mem_addr !== r_addr || mem_be !== r_be
                             || mem_wdata !== r_wdata) begin
                    stable = 0;
                end
            end
            if (out_valid) begin
                lat = k; v_data = data_out; v_alu = out_AluResult;
                v_rw = out_RegWrite; v_fm = fault_misaligned;
                v_fb = fault_bus; v_rd = out_RegDest;
                break;
            end
        end
        @(negedge clk);
        post_valid = out_valid;
        post_ready = in_ready;
    endtask

    int          w_lat;
    logic [63:0] w_r_wdata, w_v_data;
    logic [31:0] w_r_addr;
    logic [7:0]  w_r_be;

    task automatic run64(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] d);
        w_lat = 0; w_r_addr = '0; w_r_wdata = '0; w_r_be = '0; w_v_data = 'x;
        @(negedge clk);
        w_in_valid = 1'b1; w_MemRead = rd; w_MemWrite = wr;
        w_funct3 = f3; w_addr = a; w_data_in = d;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0; w_MemRead = 1'b0; w_MemWrite = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (w_mem_req) begin
                w_r_addr = w_mem_addr; w_r_wdata = w_mem_wdata;
                w_r_be = w_mem_be;
            end
            if (w_out_valid) begin
                w_lat = k; w_v_data = w_data_out;
                break;
            end
        end
    endtask

    bit seen;

    initial begin
        in_valid = 0; MemRead = 0; MemWrite = 0; funct3 = 0; addr = 0;
        data_in = 0; in_RegWrite = 0; in_RegDest = 0; in_MemToReg = 0;
        w_in_valid = 0; w_MemRead = 0; w_MemWrite = 0; w_funct3 = 0;
        w_addr = 0; w_data_in = 0;
        ack_delay = 0; never_ack = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_faults", {fault_misaligned, fault_bus}, 0);
        chk("rst_w_mem_req", w_mem_req, 0);
        rst = 1'b0;

        run_op(0, 1, SW, 32'h8, 32'h1122_3344);
        chk("sw_lat", lat, 2);
        chk("sw_req_n", req_n, 1);
        chk("sw_addr", r_addr, 32'h8);
        chk("sw_be", r_be, 4'b1111);
        chk("sw_wdata", r_wdata, 32'h1122_3344);
        chk("sw_we", r_we, 1);
        chk("sw_single_valid", post_valid, 0);

        run_op(1, 0, LW, 32'h8, 32'h0);
        chk("lw_lat", lat, 2);
        chk("lw_data", v_data, 32'h1122_3344);
        chk("lw_be", r_be, 4'b1111);
        chk("lw_we", r_we, 0);
        chk("lw_regwrite", v_rw, 1);
        chk("lw_regdest", v_rd, 5'd7);

        run_op(0, 1, SB, 32'h5, 32'h0000_00AB);
        chk("sb_addr", r_addr, 32'h4);
        chk("sb_be", r_be, 4'b0010);
        chk("sb_wdata", r_wdata, 32'hABAB_ABAB);

        run_op(1, 0, LB, 32'h5, 32'h0);
        chk("lb_data", v_data, 32'hFFFF_FFAB);
        run_op(1, 0, LBU, 32'h5, 32'h0);
        chk("lbu_data", v_data, 32'h0000_00AB);

        ack_delay = 4;
        run_op(1, 0, LW, 32'h8, 32'h0);
        chk("dly_req_n", req_n, 5);
        chk("dly_stable", stable, 1);
        chk("dly_stall", stall_ok, 1);
        chk("dly_lat", lat, 6);
        chk("dly_data", v_data, 32'h1122_3344);
        chk("dly_single_valid", post_valid, 0);
        chk("dly_ready_after", post_ready, 1);
        ack_delay = 0;

        run_op(1, 0, LH, 32'h3, 32'h0);
        chk("lh_mis_fault", v_fm, 1);
        chk("lh_mis_regwrite", v_rw, 0);
        chk("lh_mis_req_n", req_n, 0);
        chk("lh_mis_lat", lat, 1);
        chk("lh_mis_data", v_data, 0);

        run_op(0, 1, 3'b110, 32'h8, 32'h0);
        chk("su_fault", v_fm, 1);
        chk("su_req_n", req_n, 0);

        never_ack = 1;
        run_op(1, 0, LW, 32'h0, 32'h0);
        chk("to_req_n", req_n, 8);
        chk("to_lat", lat, 9);
        chk("to_fault_bus", v_fb, 1);
        chk("to_regwrite", v_rw, 0);
        chk("to_ready_after", post_ready, 1);
        never_ack = 0;

        run_op(0, 0, 3'b000, 32'h1234, 32'h0);
        chk("add_lat", lat, 1);
        chk("add_alu", v_alu, 32'h1234);
        chk("add_regwrite", v_rw, 1);
        chk("add_faults", {v_fm, v_fb}, 0);
        chk("add_req_n", req_n, 0);

        run64(0, 1, SD, 64'h10, 64'h0123_4567_89AB_CDEF);
        chk("sd_lat", w_lat, 2);
        chk("sd_be", w_r_be, 8'hFF);
        chk("sd_addr", w_r_addr, 32'h10);
        chk("sd_wdata", w_r_wdata, 64'h0123_4567_89AB_CDEF);
        run64(1, 0, LD, 64'h10, 64'h0);
        chk("ld_data", w_v_data, 64'h0123_4567_89AB_CDEF);
        chk("ld_be", w_r_be, 8'hFF);
        run64(1, 0, LW, 64'h14, 64'h0);
        chk("lw64_data", w_v_data, 64'h0000_0000_0123_4567);
        run64(1, 0, LH, 64'h12, 64'h0);
        chk("lh64_data", w_v_data, 64'hFFFF_FFFF_FFFF_89AB);

        never_ack = 1;
        issue(1, 0, LW, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstmid_req_before", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_req_drop", mem_req, 0);
        chk("rstmid_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        never_ack = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("rstmid_no_valid", seen, 0);
        chk("rstmid_ready_after", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
